// File: rtl/seg7_scan16_if.sv
// Word-load and digit-drive bundle between the system and the hex display scanner.
interface seg7_scan16_if;
   logic [15:0] din;
   logic        load;
   logic [3:0]  val;
   logic [3:0]  an;
   logic        blank;
   logic        frame;
   logic        pend;

   modport master (output din, load, input val, an, blank, frame, pend);
   modport slave  (input din, load, output val, an, blank, frame, pend);
endinterface

// File: rtl/seg7_scan16.sv
// Four-digit hex scanner for a common-anode display feeding Decoder_7seg.
// New words are staged and only swapped in at frame boundaries to avoid tearing.
module seg7_scan16 #(
   parameter int DIV      = 1000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   seg7_scan16_if.slave  bus
);

   logic [15:0] cnt;
   logic [1:0]  dig;
   logic [15:0] disp_r;
   logic [15:0] pend_r;
   logic        pend_f;
   logic        frame_r;
   logic        tick;
   logic        boundary;
   logic        blank_c;
   logic [3:0]  an_c;
   logic [3:0]  val_c;

   // Digit k is a leading zero when every nibble from k upward is zero.
   function automatic logic lz_blank(input logic [15:0] w, input logic [1:0] k);
      logic b;
      b = 1'b0;
      case (k)
         2'd1:    b = (w[15:4] == 12'd0);
         2'd2:    b = (w[15:8] == 8'd0);
         2'd3:    b = (w[15:12] == 4'd0);
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   assign tick     = (cnt == 16'(DIV - 1));
   assign boundary = tick && (dig == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         dig     <= '0;
         frame_r <= 1'b0;
      end else begin
         cnt     <= tick ? '0 : cnt + 16'd1;
         dig     <= tick ? dig + 2'd1 : dig;
         frame_r <= boundary;
      end
   end

   // A load on the boundary edge bypasses the pending stage entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_r <= '0;
         pend_r <= '0;
         pend_f <= 1'b0;
      end else if (bus.load && boundary) begin
         disp_r <= bus.din;
         pend_r <= bus.din;
         pend_f <= 1'b0;
      end else if (bus.load) begin
         pend_r <= bus.din;
         pend_f <= 1'b1;
      end else if (boundary && pend_f) begin
         disp_r <= pend_r;
         pend_f <= 1'b0;
      end
   end

   always_comb begin
      val_c   = disp_r[{dig, 2'b00} +: 4];
      blank_c = BLANK_LZ && lz_blank(disp_r, dig);
      an_c    = blank_c ? 4'b1111 : ~(4'b0001 << dig);
   end

   assign bus.val   = val_c;
   assign bus.an    = an_c;
   assign bus.blank = blank_c;
   assign bus.frame = frame_r;
   assign bus.pend  = pend_f;

endmodule

// File: tb/tb_seg7_scan16.sv
// Directed bench for seg7_scan16: two instances (blanking off/on) share one stimulus stream.
module tb_seg7_scan16;

   logic        clk;
   logic        rst_n;
   logic        ld;
   logic [15:0] d;
   int          cyc;
   int          n_chk;
   int          n_fail;

   seg7_scan16_if bus_nz ();
   seg7_scan16_if bus_lz ();

   assign bus_nz.din  = d;
   assign bus_nz.load = ld;
   assign bus_lz.din  = d;
   assign bus_lz.load = ld;

   seg7_scan16 #(.DIV(4), .BLANK_LZ(1'b0)) dut_nz (.clk(clk), .rst_n(rst_n), .bus(bus_nz));
   seg7_scan16 #(.DIV(4), .BLANK_LZ(1'b1)) dut_lz (.clk(clk), .rst_n(rst_n), .bus(bus_lz));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          at;
      logic        ld;
      logic [15:0] d;
      logic [3:0]  val;
      logic [3:0]  an_nz;
      logic [3:0]  an_lz;
      logic        blk_lz;
      logic        frame;
      logic        pend;
   } vec_t;

   vec_t t1 [35];
   vec_t t2 [5];

   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d] at cycle %0d: got %h, expected %h", name, idx, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic check_all(input int idx, input vec_t v);
      check("val_nz",   idx, 16'(bus_nz.val),   16'(v.val));
      check("val_lz",   idx, 16'(bus_lz.val),   16'(v.val));
      check("an_nz",    idx, 16'(bus_nz.an),    16'(v.an_nz));
      check("blank_nz", idx, 16'(bus_nz.blank), 16'd0);
      check("an_lz",    idx, 16'(bus_lz.an),    16'(v.an_lz));
      check("blank_lz", idx, 16'(bus_lz.blank), 16'(v.blk_lz));
      check("frame_nz", idx, 16'(bus_nz.frame), 16'(v.frame));
      check("frame_lz", idx, 16'(bus_lz.frame), 16'(v.frame));
      check("pend_nz",  idx, 16'(bus_nz.pend),  16'(v.pend));
      check("pend_lz",  idx, 16'(bus_lz.pend),  16'(v.pend));
   endtask

   // Advance to cycle v.at; a load is presented for exactly the edge that reaches it.
   task automatic run_vec(input int idx, input vec_t v);
      while (cyc < v.at - 1) step();
      if (cyc < v.at) begin
         ld = v.ld;
         d  = v.d;
         step();
         ld = 1'b0;
      end
      check_all(idx, v);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      ld     = 1'b0;
      d      = '0;
      rst_n  = 1'b0;

      //        at  ld    din       val    an_nz    an_lz    blk  frm  pend
      t1[0]  = '{  0, 1'b0, 16'h0000, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b0};
      t1[1]  = '{  3, 1'b0, 16'h0000, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b0};
      t1[2]  = '{  4, 1'b0, 16'h0000, 4'h0, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0};
      t1[3]  = '{  5, 1'b1, 16'hA3F5, 4'h0, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[4]  = '{  8, 1'b0, 16'h0000, 4'h0, 4'b1011, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[5]  = '{ 12, 1'b0, 16'h0000, 4'h0, 4'b0111, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[6]  = '{ 15, 1'b0, 16'h0000, 4'h0, 4'b0111, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[7]  = '{ 16, 1'b0, 16'h0000, 4'h5, 4'b1110, 4'b1110, 1'b0, 1'b1, 1'b0};
      t1[8]  = '{ 17, 1'b0, 16'h0000, 4'h5, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b0};
      t1[9]  = '{ 20, 1'b0, 16'h0000, 4'hF, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0};
      t1[10] = '{ 24, 1'b0, 16'h0000, 4'h3, 4'b1011, 4'b1011, 1'b0, 1'b0, 1'b0};
      t1[11] = '{ 28, 1'b0, 16'h0000, 4'hA, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0};
      t1[12] = '{ 30, 1'b1, 16'h0042, 4'hA, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b1};
      t1[13] = '{ 32, 1'b0, 16'h0000, 4'h2, 4'b1110, 4'b1110, 1'b0, 1'b1, 1'b0};
      t1[14] = '{ 36, 1'b0, 16'h0000, 4'h4, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0};
      t1[15] = '{ 40, 1'b0, 16'h0000, 4'h0, 4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0};
      t1[16] = '{ 44, 1'b0, 16'h0000, 4'h0, 4'b0111, 4'b1111, 1'b1, 1'b0, 1'b0};
      t1[17] = '{ 45, 1'b1, 16'h0700, 4'h0, 4'b0111, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[18] = '{ 48, 1'b0, 16'h0000, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b1, 1'b0};
      t1[19] = '{ 52, 1'b0, 16'h0000, 4'h0, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0};
      t1[20] = '{ 56, 1'b0, 16'h0000, 4'h7, 4'b1011, 4'b1011, 1'b0, 1'b0, 1'b0};
      t1[21] = '{ 60, 1'b0, 16'h0000, 4'h0, 4'b0111, 4'b1111, 1'b1, 1'b0, 1'b0};
      t1[22] = '{ 61, 1'b1, 16'h0000, 4'h0, 4'b0111, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[23] = '{ 64, 1'b0, 16'h0000, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b1, 1'b0};
      t1[24] = '{ 66, 1'b1, 16'h1111, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b1};
      t1[25] = '{ 68, 1'b0, 16'h0000, 4'h0, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[26] = '{ 70, 1'b1, 16'h2222, 4'h0, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b1};
      t1[27] = '{ 80, 1'b0, 16'h0000, 4'h2, 4'b1110, 4'b1110, 1'b0, 1'b1, 1'b0};
      t1[28] = '{ 84, 1'b0, 16'h0000, 4'h2, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0};
      t1[29] = '{ 85, 1'b1, 16'h2222, 4'h2, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b1};
      t1[30] = '{ 95, 1'b0, 16'h0000, 4'h2, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b1};
      t1[31] = '{ 96, 1'b1, 16'h3333, 4'h3, 4'b1110, 4'b1110, 1'b0, 1'b1, 1'b0};
      t1[32] = '{100, 1'b0, 16'h0000, 4'h3, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0};
      t1[33] = '{101, 1'b1, 16'h4444, 4'h3, 4'b1101, 4'b1101, 1'b0, 1'b0, 1'b1};
      t1[34] = '{105, 1'b0, 16'h0000, 4'h3, 4'b1011, 4'b1011, 1'b0, 1'b0, 1'b1};

      t2[0]  = '{  0, 1'b0, 16'h0000, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b0};
      t2[1]  = '{  3, 1'b0, 16'h0000, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b0, 1'b0};
      t2[2]  = '{  4, 1'b0, 16'h0000, 4'h0, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0};
      t2[3]  = '{ 16, 1'b0, 16'h0000, 4'h0, 4'b1110, 4'b1110, 1'b0, 1'b1, 1'b0};
      t2[4]  = '{ 20, 1'b0, 16'h0000, 4'h0, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0};

      #22 rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 35; i++) run_vec(i, t1[i]);

      // Asynchronous reset in the middle of digit 2 with 4444 pending, away from any edge.
      #2 rst_n = 1'b0;
      #1;
      check("async_val",   100, 16'(bus_nz.val),   16'h0);
      check("async_an_nz", 100, 16'(bus_nz.an),    16'b1110);
      check("async_an_lz", 100, 16'(bus_lz.an),    16'b1110);
      check("async_blank", 100, 16'(bus_lz.blank), 16'h0);
      check("async_frame", 100, 16'(bus_nz.frame), 16'h0);
      check("async_pend",  100, 16'(bus_nz.pend),  16'h0);
      #2 rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 5; i++) run_vec(200 + i, t2[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan16.md
# seg7_scan16

Time-multiplexed scanner for a four-digit common-anode 7-segment display showing a 16-bit value as four hex digits. It sits directly upstream of `Decoder_7seg`:
- It captures a 16-bit word from the system.
- It steps through the four digits at a programmable rate.
- It presents one nibble per digit slot on `VAL[3:0]`, which feeds the decoder, and drives the matching active-low digit enable.
- New words are applied only at frame boundaries, so the display never tears.

## Interface
- `DIV`, default 1000: `CLK` cycles per digit slot; legal range 2..65535.
- `BLANK_LZ`, default 1: 1 enables leading-zero blanking; 0 always lights all four digits.
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: reset, asynchronous and active-low.
- `DIN` in 16: word to display; `DIN[3:0]` is digit 0, the rightmost and least significant digit.
- `LOAD` in 1: single-cycle strobe; captures `DIN` as the pending word.
- `VAL` out 4: nibble for the active digit; connects to `Decoder_7seg.VAL`.
- `AN` out 4: digit enables, active-low; one-hot-low or all-high.
- `BLANK` out 1: 1 when the current slot is blanked.
- `FRAME` out 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.
- `PEND` out 1: 1 while a loaded word waits for the next frame boundary.

## Operation
- **Prescaler** `cnt`:
  - Counts 0..DIV-1.
  - `tick` = (`cnt` == DIV-1); `cnt` wraps to 0 on `tick`.
- **Digit index** `dig` (2 bits):
  - Increments on `tick`; wraps 3→0.
  - A frame boundary is a `tick` with `dig` == 3.
- **Registers:**
  - `pend_r[15:0]`: pending word.
  - `pend_f`: pending flag.
  - `disp_r[15:0]`: displayed word.
- **LOAD without boundary:** `pend_r` ← `DIN`, `pend_f` ← 1. A later LOAD before the boundary overwrites it; last wins.
- **Boundary with `pend_f` = 1 and no LOAD:** `disp_r` ← `pend_r`, `pend_f` ← 0.
- **LOAD coincident with boundary:** `disp_r` ← `DIN` directly, `pend_f` ← 0, `pend_r` ← `DIN`.
- **Boundary with no pending word:** `disp_r` is unchanged.
- **`VAL`:** `disp_r[4*dig+3 : 4*dig]`.
- **Leading-zero blanking** (`BLANK_LZ` = 1):
  - Digit k (k = 1..3) is blanked when `disp_r[15:4k]` == 0.
  - Digit 0 is never blanked.
  - A blanked slot drives `AN` = 4'b1111 and `BLANK` = 1; `VAL` still carries the nibble.
- **Unblanked slot:** `AN` has bit `dig` low and all others high; `BLANK` = 0.
- **`FRAME`:** registered. It is 1 for the single cycle after the boundary edge, i.e. coincident with the first cycle of digit 0 in the new frame.
- **`PEND`:** equals `pend_f`.

## Timing
- **Reset values:**
  - Internal: `cnt` = 0, `dig` = 0, `disp_r` = 0, `pend_r` = 0, `pend_f` = 0.
  - Outputs: `VAL` = 0, `AN` = 4'b1110, `BLANK` = 0, `FRAME` = 0, `PEND` = 0.
- **Reset assertion mid-frame:** all state clears immediately, with no clock needed. This discards any pending word.
- **Reset release:** the first slot (digit 0) lasts exactly DIV cycles.
- **Slot length:** every slot is exactly DIV cycles; a frame is 4·DIV cycles.
- **Output derivation:** `AN`, `VAL` and `BLANK` are decoded from `dig` and `disp_r`, so they change in the cycle after the `tick` edge. There is no combinational path from `DIN` or `LOAD` to any output.
- **Display latency:** from a LOAD to the word appearing is at most 4·DIV cycles.
- **`PEND` timing:** rises the cycle after LOAD and falls the cycle after the boundary.
- **`LOAD` and `DIN`:** synchronous to `CLK`; `LOAD` held high for N cycles behaves as N loads.

## Test plan
- **Reset:** `RST` = 0, then release, `DIV` = 4. Expect `AN` = 1110 and `VAL` = 0. `AN` then sequences 1101, 1011, 0111 every 4 cycles with `BLANK_LZ` = 0. `FRAME` pulses at cycles 16, 32, ….
- **Load applied at boundary:**
  - Stimulus: `BLANK_LZ` = 0, LOAD `DIN` = 16'hA3F5 in cycle 5.
  - `PEND` = 1 until the next boundary.
  - In the next frame `VAL` = 5, F, 3, A on digits 0..3.
  - The previous frame must still show 0000.
- **Leading-zero blanking:**
  - `BLANK_LZ` = 1, display 16'h0042: digits 2 and 3 give `AN` = 1111 and `BLANK` = 1; digits 0 and 1 show 2 and 4.
  - Display 16'h0000: only digit 0 is lit, showing 0.
  - Display 16'h0700: digit 1 lit with `VAL` = 0; digit 3 blanked.
- **Overwrite:**
  - LOAD 16'h1111, then LOAD 16'h2222 in the same frame: only 2222 is displayed; 1111 never appears.
  - LOAD exactly on the boundary cycle with 16'h3333 while 16'h2222 is pending: 3333 is displayed in that frame; `PEND` = 0.
- **Async reset mid-operation:**
  - Assert `RST` low mid-digit-2 with `PEND` = 1, without a clock edge.
  - Outputs return to reset values immediately.
  - After release the display shows 0 and the pending word is lost.
